// File: rtl/voltage_window_stats_pkg.sv
// Shared types and constants for the voltage window statistics block:
// report FSM state encoding, report byte tags and default sizing constants.
package voltage_window_stats_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int WIN_LOG2_DEF = 4;
   localparam logic [7:0] UV_THRESH_DEF = 8'd64;

   localparam logic [1:0] TAG_AVG = 2'd0;
   localparam logic [1:0] TAG_MIN = 2'd1;
   localparam logic [1:0] TAG_MAX = 2'd2;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AVG  = 2'd1,
      R_MIN  = 2'd2,
      R_MAX  = 2'd3
   } rpt_state_t;

endpackage

// File: rtl/voltage_window_stats_window_accumulator.sv
// Window accumulator: running sum/min/max/count over 2^WIN_LOG2 samples.
// close_s pulses combinationally on the sample that completes a window; the
// result outputs already include that sample so the caller can latch them on
// the same edge that returns the accumulators to their idle values.
module window_accumulator
   import voltage_window_stats_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              close_s,
   output logic [DATA_W-1:0] avg_s,
   output logic [DATA_W-1:0] min_s,
   output logic [DATA_W-1:0] max_s
);

   localparam int SUM_W = DATA_W + WIN_LOG2;

   logic [SUM_W-1:0]    sum_r;
   logic [WIN_LOG2-1:0] count_r;
   logic [DATA_W-1:0]   min_r;
   logic [DATA_W-1:0]   max_r;
   logic [SUM_W-1:0]    sum_next_s;
   logic                last_s;

   // Next-sample arithmetic and window-complete detection (clear suppresses the close).
   always_comb begin
      sum_next_s = sum_r + {{WIN_LOG2{1'b0}}, sample_in};
      last_s     = &count_r;
      close_s    = sample_valid & ~clear & last_s;
      min_s      = (sample_in < min_r) ? sample_in : min_r;
      max_s      = (sample_in > max_r) ? sample_in : max_r;
      avg_s      = sum_next_s[SUM_W-1:WIN_LOG2];
   end

   // Accumulator registers: flush on clear or window close, otherwise fold in the sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= {SUM_W{1'b0}};
         count_r <= {WIN_LOG2{1'b0}};
         min_r   <= {DATA_W{1'b1}};
         max_r   <= {DATA_W{1'b0}};
      end else if (clear || (sample_valid && last_s)) begin
         sum_r   <= {SUM_W{1'b0}};
         count_r <= {WIN_LOG2{1'b0}};
         min_r   <= {DATA_W{1'b1}};
         max_r   <= {DATA_W{1'b0}};
      end else if (sample_valid) begin
         sum_r   <= sum_next_s;
         count_r <= count_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
         min_r   <= min_s;
         max_r   <= max_s;
      end
   end

endmodule

// File: rtl/voltage_window_stats.sv
// Voltage window statistics: accumulates windows of samples and drains each
// window's avg/min/max as three tagged bytes over a valid/ready interface.
// A window that completes while a report is still draining is dropped and
// flagged via sticky overrun, unless the last byte is accepted that same cycle.
// Optional feature macro: UNDERVOLT_ALARM_EN (adds uv_alarm and a run counter).
module voltage_window_stats
   import voltage_window_stats_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
`ifdef UNDERVOLT_ALARM_EN
   ,
   parameter logic [DATA_W-1:0] UV_THRESH = DATA_W'(UV_THRESH_DEF)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              clear,
   output logic [DATA_W-1:0] report_data,
   output logic [1:0]        report_tag,
   output logic              report_valid,
   input  logic              report_ready,
   output logic              overrun
`ifdef UNDERVOLT_ALARM_EN
   ,
   output logic              uv_alarm
`endif
);

   rpt_state_t        state_r, state_next_s;
   logic              win_close_s;
   logic [DATA_W-1:0] win_avg_s, win_min_s, win_max_s;
   logic [DATA_W-1:0] res_avg_r, res_min_r, res_max_r;
   logic [DATA_W-1:0] res_avg_next_s, res_min_next_s, res_max_next_s;
   logic [DATA_W-1:0] data_next_s;
   logic [1:0]        tag_next_s;
   logic              valid_next_s, overrun_next_s;
   logic              accept_s, load_s, drop_s;

   window_accumulator #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_acc (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .close_s      (win_close_s),
      .avg_s        (win_avg_s),
      .min_s        (win_min_s),
      .max_s        (win_max_s)
   );

   // Report FSM next state, result capture, drop detection and next output byte.
   always_comb begin
      state_next_s   = state_r;
      load_s         = 1'b0;
      drop_s         = 1'b0;
      accept_s       = report_valid & report_ready;
      if (clear) begin
         state_next_s = R_IDLE;
      end else begin
         case (state_r)
            R_IDLE: begin
               if (win_close_s) begin
                  load_s       = 1'b1;
                  state_next_s = R_AVG;
               end else begin
                  state_next_s = R_IDLE;
               end
            end
            R_AVG: begin
               drop_s       = win_close_s;
               state_next_s = accept_s ? R_MIN : R_AVG;
            end
            R_MIN: begin
               drop_s       = win_close_s;
               state_next_s = accept_s ? R_MAX : R_MIN;
            end
            R_MAX: begin
               if (accept_s) begin
                  // Last byte leaves as a new window lands: chain straight into it.
                  load_s       = win_close_s;
                  state_next_s = win_close_s ? R_AVG : R_IDLE;
               end else begin
                  drop_s       = win_close_s;
                  state_next_s = R_MAX;
               end
            end
            default: state_next_s = R_IDLE;
         endcase
      end

      if (load_s) begin
         res_avg_next_s = win_avg_s;
         res_min_next_s = win_min_s;
         res_max_next_s = win_max_s;
      end else begin
         res_avg_next_s = res_avg_r;
         res_min_next_s = res_min_r;
         res_max_next_s = res_max_r;
      end

      case (state_next_s)
         R_AVG:   begin data_next_s = res_avg_next_s; tag_next_s = TAG_AVG; end
         R_MIN:   begin data_next_s = res_min_next_s; tag_next_s = TAG_MIN; end
         R_MAX:   begin data_next_s = res_max_next_s; tag_next_s = TAG_MAX; end
         default: begin data_next_s = {DATA_W{1'b0}}; tag_next_s = TAG_AVG; end
      endcase

      valid_next_s   = (state_next_s != R_IDLE);
      overrun_next_s = clear ? 1'b0 : (overrun | drop_s);
   end

   // Report state, held results and registered report outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= R_IDLE;
         res_avg_r    <= {DATA_W{1'b0}};
         res_min_r    <= {DATA_W{1'b0}};
         res_max_r    <= {DATA_W{1'b0}};
         report_data  <= {DATA_W{1'b0}};
         report_tag   <= TAG_AVG;
         report_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         res_avg_r    <= res_avg_next_s;
         res_min_r    <= res_min_next_s;
         res_max_r    <= res_max_next_s;
         report_data  <= data_next_s;
         report_tag   <= tag_next_s;
         report_valid <= valid_next_s;
         overrun      <= overrun_next_s;
      end
   end

`ifdef UNDERVOLT_ALARM_EN
   logic [1:0] uv_run_r;

   // Undervoltage run tracking: alarm after four consecutive low valid samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uv_run_r <= 2'd0;
         uv_alarm <= 1'b0;
      end else if (clear) begin
         uv_run_r <= 2'd0;
         uv_alarm <= 1'b0;
      end else if (sample_valid) begin
         if (sample_in < UV_THRESH) begin
            if (uv_run_r == 2'd3) begin
               uv_alarm <= 1'b1;
            end else begin
               uv_run_r <= uv_run_r + 2'd1;
            end
         end else begin
            uv_run_r <= 2'd0;
            uv_alarm <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_voltage_window_stats.sv
// Self-checking bench for voltage_window_stats: a reference model builds the
// expected report bytes from whole windows of samples and pushes them into a
// scoreboard queue; a monitor on the falling edge compares the presented bytes.
module tb_voltage_window_stats;

   localparam int WL = 4;
   localparam int WN = 1 << WL;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       clear;
   logic [7:0] report_data;
   logic [1:0] report_tag;
   logic       report_valid;
   logic       report_ready;
   logic       overrun;
`ifdef UNDERVOLT_ALARM_EN
   logic       uv_alarm;
   int         uv_run = 0;
   bit         uv_exp = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic [9:0] exp_q[$];   // {tag, data}
   int         pending = 0;
   bit         ovr_exp = 1'b0;
   int         win_q[$];

   voltage_window_stats #(.DATA_W(8), .WIN_LOG2(WL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .clear        (clear),
      .report_data  (report_data),
      .report_tag   (report_tag),
      .report_valid (report_valid),
      .report_ready (report_ready),
      .overrun      (overrun)
`ifdef UNDERVOLT_ALARM_EN
      ,
      .uv_alarm     (uv_alarm)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
      sample_valid = v;
      sample_in    = d;
      report_ready = r;
      clear        = c;
      @(posedge clk);
      #1;
   endtask

   // Reference model: collects whole windows and decides load vs. drop by report occupancy.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            win_q.delete();
            pending = 0;
            ovr_exp = 1'b0;
`ifdef UNDERVOLT_ALARM_EN
            uv_run = 0;
            uv_exp = 1'b0;
`endif
         end else begin
            bit acc;
            bit loaded;
            int sum, mn, mx;
            acc    = (pending > 0) && report_ready;
            loaded = 1'b0;
            if (clear) begin
               win_q.delete();
               exp_q.delete();
               pending = 0;
               ovr_exp = 1'b0;
`ifdef UNDERVOLT_ALARM_EN
               uv_run = 0;
               uv_exp = 1'b0;
`endif
            end else begin
               if (sample_valid) begin
                  win_q.push_back(int'(sample_in));
`ifdef UNDERVOLT_ALARM_EN
                  if (sample_in < 8'd64) begin
                     uv_run++;
                     if (uv_run >= 4) uv_exp = 1'b1;
                  end else begin
                     uv_run = 0;
                     uv_exp = 1'b0;
                  end
`endif
               end
               if (win_q.size() == WN) begin
                  sum = 0; mn = 255; mx = 0;
                  foreach (win_q[k]) begin
                     sum += win_q[k];
                     if (win_q[k] < mn) mn = win_q[k];
                     if (win_q[k] > mx) mx = win_q[k];
                  end
                  if (pending == 0 || (pending == 1 && acc)) begin
                     exp_q.push_back({2'd0, 8'(sum / WN)});
                     exp_q.push_back({2'd1, 8'(mn)});
                     exp_q.push_back({2'd2, 8'(mx)});
                     loaded = 1'b1;
                  end else begin
                     ovr_exp = 1'b1;
                  end
                  win_q.delete();
               end
               if (acc) pending--;
               if (loaded) pending = 3;
            end
         end
      end
   end

   // Monitor: compares presented bytes against the scoreboard and pops on acceptance.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_valid", int'(report_valid), 0);
            chk("rst_data", int'(report_data), 0);
            chk("rst_overrun", int'(overrun), 0);
         end else begin
            chk("valid", int'(report_valid), int'(pending > 0));
            chk("overrun", int'(overrun), int'(ovr_exp));
`ifdef UNDERVOLT_ALARM_EN
            chk("uv_alarm", int'(uv_alarm), int'(uv_exp));
`endif
            if (report_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", int'({report_tag, report_data}), -1);
               end else begin
                  chk("byte", int'({report_tag, report_data}), int'(exp_q[0]));
                  if (report_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; sample_in = 8'd0; clear = 1'b0; report_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_valid", int'(report_valid), 0);
      chk("reset_tag", int'(report_tag), 0);
      chk("reset_overrun", int'(overrun), 0);

      // Ramp 0..15: avg 7, min 0, max 15 on consecutive cycles.
      for (int i = 0; i < WN; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
      chk("ramp_avg", int'({report_tag, report_data}), 7);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ramp_min", int'({report_tag, report_data}), 256 + 0);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ramp_max", int'({report_tag, report_data}), 512 + 15);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ramp_idle", int'(report_valid), 0);

      // All-ones window: no sum overflow.
      for (int i = 0; i < WN; i++) drive(1'b1, 8'hFF, 1'b1, 1'b0);
      chk("ff_avg", int'({report_tag, report_data}), 255);
      repeat (4) drive(1'b0, 8'd0, 1'b1, 1'b0);

      // Stalled consumer: second window dropped, then clear.
      for (int i = 0; i < 40; i++) drive(i < 32, 8'($urandom), 1'b0, 1'b0);
      chk("stall_overrun", int'(overrun), 1);
      chk("stall_valid", int'(report_valid), 1);
      drive(1'b0, 8'd0, 1'b0, 1'b1);
      chk("clear_overrun", int'(overrun), 0);
      chk("clear_valid", int'(report_valid), 0);

      // Window 2 closes on the cycle the max byte of window 1 is accepted.
      for (int i = 0; i < 3 * WN; i++) drive(1'b1, 8'($urandom), i >= 29, 1'b0);
      repeat (4) drive(1'b0, 8'd0, 1'b1, 1'b0);

      // Reset while the min byte is presented.
      for (int i = 0; i < WN; i++) drive(1'b1, 8'(i * 3), 1'b0, 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("pre_reset_tag", int'(report_tag), 1);
      report_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", int'(report_valid), 0);
      chk("async_data", int'(report_data), 0);
      chk("async_tag", int'(report_tag), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("post_reset_valid", int'(report_valid), 0);
      for (int i = 0; i < WN; i++) drive(1'b1, 8'd10, 1'b1, 1'b0);
      chk("ten_avg", int'({report_tag, report_data}), 10);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ten_min", int'({report_tag, report_data}), 256 + 10);
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("ten_max", int'({report_tag, report_data}), 512 + 10);
      drive(1'b0, 8'd0, 1'b1, 1'b0);

`ifdef UNDERVOLT_ALARM_EN
      drive(1'b1, 8'd100, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'd63, 1'b1, 1'b0);
      chk("uv_three", int'(uv_alarm), 0);
      drive(1'b1, 8'd63, 1'b1, 1'b0);
      chk("uv_four", int'(uv_alarm), 1);
      drive(1'b1, 8'd64, 1'b1, 1'b0);
      chk("uv_release", int'(uv_alarm), 0);
`endif

      // Randomized traffic with occasional clears and a throttled consumer.
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom % 4) != 0,
               ($urandom % 2) ? 8'($urandom_range(0, 80)) : 8'($urandom),
               ($urandom % 3) != 0,
               ($urandom % 97) == 0);
      end

      // Bounded drain.
      for (int i = 0; i < 20; i++) drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
